instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, address of the first fetch after reset.
REQ-002 Parameter: PC_STEP, 2, byte increment between sequential 16-bit instructions.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: imem_req  output  1  instruction-memory read request.
REQ-006 Port: imem_addr  output  16  byte address of the request.
REQ-007 Port: imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle.
REQ-008 Port: imem_rdata  input  16  instruction word.
REQ-009 Port: branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-010 Port: branch_target  input  16  redirect address.
REQ-011 Port: stall  input  1  decode not ready to consume.
REQ-012 Port: if_valid  output  1  if_instr/if_pc hold a live instruction.
REQ-013 Port: if_instr  output  16  fetched instruction.
REQ-014 Port: if_pc  output  16  address of if_instr.
REQ-015 Port: opcode  output  4  if_instr[15:12], combinational; feeds the control-unit decoder.
REQ-016 Port: misalign  output  1  sticky flag, odd branch_target received.
REQ-017 Port: fetch_count  output  16  count of instructions delivered.

Function
REQ-018 FSM states SHALL be IDLE, REQ, DRAIN, HOLD; priority per cycle: reset > branch_taken > imem_ack > stall.
REQ-019 IDLE: imem_req=0; unconditionally -> REQ next cycle, latching imem_addr<=pc.
REQ-020 REQ: imem_req=1, imem_addr stable until imem_ack; on ack without branch: if_instr<=imem_rdata, if_pc<=imem_addr, if_valid<=1, pc<=pc+PC_STEP, fetch_count+1, -> HOLD.
REQ-021 pc and fetch_count SHALL wrap modulo 2^16 (pc 16'hFFFE -> 16'h0000; count 16'hFFFF -> 0).
REQ-022 REQ with branch_taken and no ack: pc<=target, -> DRAIN (outstanding request must complete).
REQ-023 REQ with branch_taken and ack same cycle: rdata discarded, count unchanged, pc<=target, -> REQ with imem_addr<=target next cycle.
REQ-024 DRAIN: imem_req=1 with the old address held; on ack data discarded, -> REQ with imem_addr<=pc; further branch_taken updates pc, stays in DRAIN.
REQ-025 HOLD: if_valid=1; stall=1 holds all outputs unchanged; stall=0 -> REQ, if_valid<=0, imem_addr<=pc.
REQ-026 HOLD with branch_taken (regardless of stall): if_valid<=0, if_instr<=0, pc<=target, -> REQ.
REQ-027 branch_target[0]=1: bit 0 forced to 0 before use and misalign set; misalign clears only on reset.
REQ-028 imem_ack outside REQ/DRAIN SHALL be ignored.
REQ-029 Fetch-to-if_valid latency: one cycle after the ack cycle; minimum sequential throughput one instruction per 2 cycles.

Reset
REQ-030 On reset: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, misalign=0, fetch_count=0.
REQ-031 Reset asserted mid-request SHALL abandon the request; an ack arriving during or after reset while in IDLE is ignored.

Structure
REQ-032 Shared package cpu16_pkg SHALL hold the FSM state encoding, RESET_PC default, PC_STEP, and opcode field bounds [15:12].
REQ-033 One sub-module program_counter SHALL hold pc with load (redirect), increment, and reset controls; FSM and output registers stay in instruction_fetch.

Verification
REQ-034 Reset release, memory acks 1 cycle after each req with 0x1xxx words -> imem_addr 0x0000, 0x0002, 0x0004; if_valid pulses; fetch_count 3.
REQ-035 stall=1 for 5 cycles in HOLD -> if_instr/if_pc/if_valid frozen, imem_req=0, no new fetch.
REQ-036 branch_taken target 0x0040 while req outstanding (ack 3 cycles later) -> old data dropped, next imem_addr 0x0040, count unchanged.
REQ-037 branch_taken with ack same cycle, target 0x0100 -> no if_valid for that data, next imem_addr 0x0100.
REQ-038 branch_target 0x0081 -> fetch from 0x0080, misalign=1 until reset.
REQ-039 pc at 0xFFFE acked -> next imem_addr 0x0000; reset mid-REQ -> IDLE, outputs at reset values.

Source files
------------

// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU front end: fetch FSM states,
// program-counter defaults and the opcode field position.
package cpu16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [15:0] PC_STEP_DEFAULT  = 16'd2;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  // Instructions are halfword aligned, so a redirect never lands on an odd byte.
  function automatic logic [15:0] align_target(input logic [15:0] target);
    return {target[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// Program counter register: redirect load has priority over sequential step;
// the step wraps naturally modulo 2^16.
module program_counter
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [15:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        inc,
  output logic [15:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one halfword read at a time, tracks branch
// redirects against the outstanding request and holds the fetched word for decode.
module instruction_fetch
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [15:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        stall,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [3:0]  opcode,
  output logic        misalign,
  output logic [15:0] fetch_count
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  target;
  logic         pc_load;
  logic         pc_inc;

  assign target  = align_target(branch_target);
  assign pc_load = branch_taken;
  assign pc_inc  = !branch_taken && imem_ack && (state == REQ);
  assign opcode  = if_instr[OPCODE_MSB:OPCODE_LSB];

  program_counter #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .load       (pc_load),
    .load_value (target),
    .inc        (pc_inc),
    .pc         (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 16'h0000;
      if_pc       <= 16'h0000;
      misalign    <= 1'b0;
      fetch_count <= 16'h0000;
    end else begin
      if (branch_taken && branch_target[0]) begin
        misalign <= 1'b1;
      end
      case (state)
        IDLE: begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= branch_taken ? target : pc;
        end
        REQ: begin
          if (branch_taken && imem_ack) begin
            imem_addr <= target;
          end else if (branch_taken) begin
            // The old request is still in flight; wait for its ack before reissuing.
            state <= DRAIN;
          end else if (imem_ack) begin
            state       <= HOLD;
            imem_req    <= 1'b0;
            if_valid    <= 1'b1;
            if_instr    <= imem_rdata;
            if_pc       <= imem_addr;
            fetch_count <= fetch_count + 16'd1;
          end
        end
        DRAIN: begin
          if (!branch_taken && imem_ack) begin
            state     <= REQ;
            imem_addr <= pc;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= target;
            if_valid  <= 1'b0;
            if_instr  <= 16'h0000;
          end else if (!stall) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc;
            if_valid  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a transaction-level reference model is
// compared every cycle, and literal expectations pin each scenario.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [3:0]  opcode;
  logic        misalign;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .opcode        (opcode),
    .misalign      (misalign),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {4'h1, a[11:0]};
  endfunction

  // Reference model: one request in flight at most; a redirect while it is
  // in flight marks its data as stale; a delivered word waits until decode takes it.
  logic        m_ok = 1'b0;
  logic        m_req, m_drop, m_launch, m_valid, m_mis;
  logic [15:0] m_addr, m_pc, m_instr, m_ipc, m_count;

  always @(posedge clk) begin
    logic [15:0] tgt;
    tgt = {branch_target[15:1], 1'b0};
    if (reset) begin
      m_req = 0; m_drop = 0; m_launch = 1; m_valid = 0; m_mis = 0;
      m_addr = 16'h0000; m_pc = 16'h0000; m_instr = 0; m_ipc = 0; m_count = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      if (branch_taken) begin
        if (branch_target[0]) m_mis = 1;
        m_pc = tgt;
        if (m_req && (m_drop || !imem_ack)) begin
          m_drop = 1;
        end else begin
          if (m_valid) m_instr = 0;
          m_valid = 0; m_req = 1; m_addr = tgt; m_launch = 0;
        end
      end else if (m_req && imem_ack) begin
        if (m_drop) begin
          m_drop = 0; m_addr = m_pc;
        end else begin
          m_instr = imem_rdata; m_ipc = m_addr; m_valid = 1; m_req = 0;
          m_count = m_count + 1; m_pc = m_pc + 2;
        end
      end else if (m_launch) begin
        m_launch = 0; m_req = 1; m_addr = m_pc;
      end else if (m_valid && !stall) begin
        m_valid = 0; m_req = 1; m_addr = m_pc;
      end
    end
    #1;
    if (m_ok) begin
      chk("cyc_imem_req", {15'd0, imem_req}, {15'd0, m_req});
      chk("cyc_imem_addr", imem_addr, m_addr);
      chk("cyc_if_valid", {15'd0, if_valid}, {15'd0, m_valid});
      chk("cyc_if_instr", if_instr, m_instr);
      chk("cyc_if_pc", if_pc, m_ipc);
      chk("cyc_opcode", {12'd0, opcode}, {12'd0, m_instr[15:12]});
      chk("cyc_misalign", {15'd0, misalign}, {15'd0, m_mis});
      chk("cyc_fetch_count", fetch_count, m_count);
    end
  end

  task automatic wait_req();
    int t = 0;
    while (!imem_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!imem_req) chk("timeout_req", 16'd0, 16'd1);
  endtask

  task automatic serve(input int lat, output logic [15:0] addr_seen);
    wait_req();
    addr_seen = imem_addr;
    repeat (lat) @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = mem_word(imem_addr);
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    $display("fetch addr=%h instr=%h pc=%h count=%0d", addr_seen, if_instr, if_pc, fetch_count);
  endtask

  task automatic branch(input logic [15:0] t, input logic with_ack);
    branch_taken = 1'b1;
    branch_target = t;
    if (with_ack) begin
      imem_ack = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end
    @(negedge clk);
    branch_taken = 1'b0;
    imem_ack = 1'b0;
    $display("branch target=%h ack=%0d -> addr=%h req=%0d", t, with_ack, imem_addr, imem_req);
  endtask

  initial begin
    logic [15:0] a;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    repeat (2) @(negedge clk);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_count", fetch_count, 16'h0000);
    reset = 1'b0;

    // Three back-to-back sequential fetches.
    serve(0, a); chk("seq_addr0", a, 16'h0000);
    serve(0, a); chk("seq_addr1", a, 16'h0002);
    serve(0, a); chk("seq_addr2", a, 16'h0004);
    chk("seq_count", fetch_count, 16'd3);
    chk("seq_valid", {15'd0, if_valid}, 16'd1);
    chk("seq_instr", if_instr, 16'h1004);

    // Decode stalls for five cycles.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req", {15'd0, imem_req}, 16'd0);
      chk("stall_instr", if_instr, 16'h1004);
      chk("stall_pc", if_pc, 16'h0004);
      chk("stall_valid", {15'd0, if_valid}, 16'd1);
    end
    stall = 1'b0;

    // Redirect with the request outstanding; its ack comes three cycles later.
    wait_req();
    chk("drain_old_addr", imem_addr, 16'h0006);
    branch(16'h0040, 1'b0);
    chk("drain_held_addr", imem_addr, 16'h0006);
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = mem_word(16'h0006);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("drain_valid", {15'd0, if_valid}, 16'd0);
    chk("drain_count", fetch_count, 16'd3);
    chk("drain_next_addr", imem_addr, 16'h0040);
    serve(0, a); chk("drain_fetch_addr", a, 16'h0040);
    chk("drain_instr", if_instr, 16'h1040);
    chk("drain_new_count", fetch_count, 16'd4);

    // Redirect in the same cycle as the ack.
    wait_req();
    chk("same_old_addr", imem_addr, 16'h0042);
    branch(16'h0100, 1'b1);
    chk("same_valid", {15'd0, if_valid}, 16'd0);
    chk("same_addr", imem_addr, 16'h0100);
    chk("same_count", fetch_count, 16'd4);
    serve(0, a); chk("same_fetch_pc", if_pc, 16'h0100);

    // Odd redirect target from HOLD.
    branch(16'h0081, 1'b0);
    chk("mis_addr", imem_addr, 16'h0080);
    chk("mis_flag", {15'd0, misalign}, 16'd1);
    chk("mis_instr_clr", if_instr, 16'h0000);
    serve(1, a); chk("mis_fetch_pc", if_pc, 16'h0080);
    chk("mis_opcode", {12'd0, opcode}, 16'd1);

    // Top-of-memory wrap.
    branch(16'hFFFE, 1'b0);
    serve(0, a); chk("wrap_fetch_pc", if_pc, 16'hFFFE);
    wait_req();
    chk("wrap_next_addr", imem_addr, 16'h0000);
    chk("wrap_mis_sticky", {15'd0, misalign}, 16'd1);

    // Reset mid-request, with acks during reset and in IDLE.
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1234;
    @(negedge clk);
    chk("rst2_req", {15'd0, imem_req}, 16'd0);
    chk("rst2_addr", imem_addr, 16'h0000);
    chk("rst2_valid", {15'd0, if_valid}, 16'd0);
    chk("rst2_instr", if_instr, 16'h0000);
    chk("rst2_pc", if_pc, 16'h0000);
    chk("rst2_mis", {15'd0, misalign}, 16'd0);
    chk("rst2_count", fetch_count, 16'd0);
    reset = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("idle_ack_count", fetch_count, 16'd0);
    chk("idle_ack_req", {15'd0, imem_req}, 16'd1);
    serve(0, a); chk("post_rst_addr", a, 16'h0000);
    chk("post_rst_count", fetch_count, 16'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
